// File: rtl/pc_fetch_buf.sv
// Fetch stage: PC generation, ROM enable and a DEPTH-entry prefetch FIFO.
// Optional FETCH_PERF_EN macro adds saturating fetch/flush event counters.
module pc_fetch_buf #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic full;
    logic pop;
    logic push;
    logic unused_tgt;

    // Target is word aligned; the two low bits are dropped on redirect.
    assign unused_tgt = ^branch_target_i[1:0];

    assign full       = (count == FULL_CNT);
    assign id_valid_o = (count != '0);
    assign pop        = id_valid_o & id_ready_i;
    assign push       = (state == RUN) & ~branch_flag_i & (~full | pop);

    assign rom_addr_o = pc;
    assign id_pc_o    = id_valid_o ? pc_mem[rd_ptr] : 32'h0;
    assign id_inst_o  = id_valid_o ? inst_mem[rd_ptr] : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_ce_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= RUN;
                    rom_ce_o <= 1'b1;
                end
                RUN: begin
                    state    <= RUN;
                    rom_ce_o <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    rom_ce_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (branch_flag_i) begin
            pc <= {branch_target_i[31:2], 2'b00};
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (branch_flag_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= pc;
            inst_mem[wr_ptr] <= rom_inst_i;
        end
    end

`ifdef FETCH_PERF_EN
    logic [CW-1:0] discard;
    logic [32:0]   flush_sum;

    // A pop completing on the redirect edge is delivered, not discarded.
    assign discard   = branch_flag_i ? (count - CW'(pop)) : '0;
    assign flush_sum = {1'b0, perf_flush_cnt_o} + 33'(discard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt_o <= 32'h0;
            perf_flush_cnt_o <= 32'h0;
        end else begin
            if (push && (perf_fetch_cnt_o != 32'hFFFF_FFFF)) begin
                perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
            end
            if (flush_sum[32]) begin
                perf_flush_cnt_o <= 32'hFFFF_FFFF;
            end else begin
                perf_flush_cnt_o <= flush_sum[31:0];
            end
        end
    end
`endif

endmodule
